pwm_duty_calc: RTL

Downstream consumer of the PWM period/high-time measurement stage. Takes the raw period and high-time counts in clk cycles and produces a normalised unsigned Q0.16 duty fraction through a sequential 16-iteration restoring divider. Also flags a lost input signal with an edge watchdog. Output feeds the register map read by the host.

---
 rtl/pwm_duty_calc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_calc.sv
// PWM duty calculator: turns measured period/high counts into a Q0.16 duty fraction
// using a 16-step restoring divider, and flags a lost input with an edge watchdog.
module pwm_duty_calc #(
  parameter int TIMEOUT = 1000000,
  parameter int W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period,
  input  logic [W-1:0] high,
  input  logic         sig,
  output logic [W-1:0] duty,
  output logic         duty_valid,
  output logic         busy,
  output logic         err,
  output logic         lost
);

  localparam int           CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

  // Watchdog signals
  logic          r_sig_s1, r_sig_s2, r_sig_prev;
  logic [CW-1:0] r_wd_cnt;
  logic          r_lost;
  logic          w_edge;
  logic          w_lost_next;

  // Divider / FSM signals
  state_t        r_state;
  logic          r_pending;
  logic [W-1:0]  r_prev_period, r_prev_high;
  logic [W-1:0]  r_p, r_rem, r_quot;
  logic [3:0]    r_iter;
  logic [W-1:0]  r_duty;
  logic          r_duty_valid, r_busy, r_err;

  logic          w_start;
  logic [W:0]    w_rem2, w_diff;
  logic          w_ge;
  logic [W-1:0]  w_rem_next, w_quot_next;
  logic          w_fin, w_fin_err;
  logic [W-1:0]  w_fin_q;

  assign w_edge      = r_sig_s2 ^ r_sig_prev;
  assign w_lost_next = w_edge ? 1'b0 : ((r_wd_cnt == TO_VAL) ? 1'b1 : r_lost);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_s1   <= 1'b0;
      r_sig_s2   <= 1'b0;
      r_sig_prev <= 1'b0;
      r_wd_cnt   <= '0;
      r_lost     <= 1'b0;
    end else begin
      r_sig_s1   <= sig;
      r_sig_s2   <= r_sig_s1;
      r_sig_prev <= r_sig_s2;
      if (w_edge)
        r_wd_cnt <= '0;
      else if (r_wd_cnt != TO_VAL)
        r_wd_cnt <= r_wd_cnt + CW'(1);
      r_lost     <= w_lost_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_period <= '0;
      r_prev_high   <= '0;
    end else begin
      r_prev_period <= period;
      r_prev_high   <= high;
    end
  end

  assign w_start     = (period != r_prev_period) || (high != r_prev_high);
  assign w_rem2      = {r_rem, 1'b0};
  assign w_diff      = w_rem2 - {1'b0, r_p};
  assign w_ge        = (w_rem2 >= {1'b0, r_p});
  assign w_rem_next  = w_ge ? w_diff[W-1:0] : w_rem2[W-1:0];
  assign w_quot_next = {r_quot[W-2:0], w_ge};

  // Result produced on the edge that enters DONE, so duty is visible during the DONE cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fin     = 1'b0;
    w_fin_q   = '0;
    w_fin_err = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (period == '0) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else if (high >= period) begin
          w_fin   = 1'b1;
          w_fin_q = '1;
        end
      end
      S_DIV: begin
        if (r_iter == 4'd15) begin
          w_fin   = 1'b1;
          w_fin_q = w_quot_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b0;
      r_p          <= '0;
      r_rem        <= '0;
      r_quot       <= '0;
      r_iter       <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      if (w_lost_next)
        r_duty <= '0;
      if (w_start && r_state != S_IDLE)
        r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start || r_pending) begin
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        S_LOAD: begin
          r_p     <= period;
          r_rem   <= high;
          r_quot  <= '0;
          r_iter  <= '0;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_iter <= r_iter + 4'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Results computed while the input is lost are dropped.
      if (w_fin) begin
        r_state <= S_DONE;
        if (!w_lost_next) begin
          r_duty       <= w_fin_q;
          r_err        <= w_fin_err;
          r_duty_valid <= 1'b1;
        end
      end
    end
  end

  assign duty       = r_duty;
  assign duty_valid = r_duty_valid;
  assign busy       = r_busy;
  assign err        = r_err;
  assign lost       = r_lost;

endmodule
